// File: rtl/alu_pkg.sv
// Shared types and constants for the streaming ALU: opcodes, FSM encodings, status flags.
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned ST_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef logic [ST_W-1:0] state_e;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_MUL  = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  localparam int unsigned FLG_CARRY = 0;
  localparam int unsigned FLG_OVF   = 1;
  localparam int unsigned FLG_ZERO  = 2;
  localparam int unsigned FLG_NEG   = 3;
  localparam int unsigned FLG_ERR   = 4;

  // Field order matches the FLG_* bit indices (err is the MSB).
  typedef struct packed {
    logic err;
    logic neg;
    logic zero;
    logic ovf;
    logic carry;
  } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [2*WIDTH-1:0] p_in_c;
  logic [WIDTH-1:0]   mc_in_c;
  logic [WIDTH:0]     sum_c;
  logic [2*WIDTH-1:0] step_c;

  // The first step is taken on the start cycle itself so the product is ready after WIDTH edges.
  always_comb begin
    p_in_c  = start_i ? {{WIDTH{1'b0}}, b_i} : p_q;
    mc_in_c = start_i ? a_i : mcand_q;
    sum_c   = {1'b0, p_in_c[2*WIDTH-1:WIDTH]} + (p_in_c[0] ? {1'b0, mc_in_c} : {(WIDTH+1){1'b0}});
    step_c  = {sum_c, p_in_c[WIDTH-1:1]};
  end

  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mcand_d = mcand_q;
    p_d     = p_q;
    if (start_i) begin
      busy_d  = 1'b1;
      cnt_d   = CNT_W'(WIDTH - 1);
      mcand_d = a_i;
      p_d     = step_c;
    end else if (busy_q) begin
      p_d   = step_c;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mcand_q <= '0;
      p_q     <= '0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
    end
  end

  assign done_o = done_q;
  assign prod_o = p_q;

endmodule

// File: rtl/alu_stream.sv
// Streaming ALU with ready/valid on both sides, tag sideband, status flags and a
// sequential multiplier; one operation in flight at a time.
module alu_stream
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_lo,
  output logic [WIDTH-1:0]  out_hi,
  output logic [FLAG_W-1:0] out_flags,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  state_e             st_q, st_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_lo_q, out_lo_d;
  logic [WIDTH-1:0]   out_hi_q, out_hi_d;
  flags_t             out_flags_q, out_flags_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic [TAG_W-1:0]   mul_tag_q, mul_tag_d;

  op_e                op_c;
  logic               in_ready_c;
  logic               accept_c;
  logic               mul_start_c;
  logic [WIDTH:0]     sum_c;
  logic [WIDTH:0]     diff_c;
  logic [SH_W-1:0]    shamt_c;
  logic [WIDTH-1:0]   alu_lo_c;
  flags_t             alu_flags_c;
  flags_t             mul_flags_c;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign op_c = op_e'(in_op);

  // Single-cycle datapath; arithmetic at WIDTH+1 bits so carry/borrow fall out of the MSB.
  always_comb begin
    alu_lo_c    = '0;
    alu_flags_c = '0;
    sum_c       = {1'b0, in_a} + {1'b0, in_b};
    diff_c      = {1'b0, in_a} - {1'b0, in_b};
    shamt_c     = in_b[SH_W-1:0];
    case (op_c)
      OP_ADD: begin
        alu_lo_c          = sum_c[WIDTH-1:0];
        alu_flags_c.carry = sum_c[WIDTH];
        alu_flags_c.ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_c[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_lo_c          = diff_c[WIDTH-1:0];
        alu_flags_c.carry = diff_c[WIDTH];
        alu_flags_c.ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff_c[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_lo_c = in_a & in_b;
      OP_OR:   alu_lo_c = in_a | in_b;
      OP_XOR:  alu_lo_c = in_a ^ in_b;
      OP_SHL:  alu_lo_c = in_a << shamt_c;
      OP_SHR:  alu_lo_c = in_a >> shamt_c;
      OP_SRA:  alu_lo_c = $unsigned($signed(in_a) >>> shamt_c);
      OP_SLT:  alu_lo_c = WIDTH'($signed(in_a) < $signed(in_b));
      OP_SLTU: alu_lo_c = WIDTH'(in_a < in_b);
      OP_MUL:  alu_lo_c = '0;
      default: alu_flags_c.err = 1'b1;
    endcase
    alu_flags_c.zero = (alu_lo_c == '0);
    alu_flags_c.neg  = alu_lo_c[WIDTH-1];
  end

  always_comb begin
    mul_flags_c      = '0;
    mul_flags_c.zero = (mul_prod == '0);
    mul_flags_c.neg  = mul_prod[2*WIDTH-1];
  end

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start_c),
    .a_i     (in_a),
    .b_i     (in_b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Next-state and output-register logic.
  always_comb begin
    st_d        = st_q;
    out_valid_d = out_valid_q;
    out_lo_d    = out_lo_q;
    out_hi_d    = out_hi_q;
    out_flags_d = out_flags_q;
    out_tag_d   = out_tag_q;
    mul_tag_d   = mul_tag_q;
    in_ready_c  = (st_q == ST_IDLE) || ((st_q == ST_DONE) && out_ready);
    accept_c    = in_valid && in_ready_c;
    mul_start_c = accept_c && (op_c == OP_MUL);
    case (st_q)
      ST_IDLE, ST_DONE: begin
        if (accept_c) begin
          if (op_c == OP_MUL) begin
            st_d        = ST_MUL;
            out_valid_d = 1'b0;
            mul_tag_d   = in_tag;
          end else begin
            st_d        = ST_DONE;
            out_valid_d = 1'b1;
            out_lo_d    = alu_lo_c;
            out_hi_d    = '0;
            out_flags_d = alu_flags_c;
            out_tag_d   = in_tag;
          end
        end else if ((st_q == ST_DONE) && out_ready) begin
          st_d        = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          st_d        = ST_DONE;
          out_valid_d = 1'b1;
          out_lo_d    = mul_prod[WIDTH-1:0];
          out_hi_d    = mul_prod[2*WIDTH-1:WIDTH];
          out_flags_d = mul_flags_c;
          out_tag_d   = mul_tag_q;
        end
      end
      default: begin
        st_d        = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_lo_q    <= '0;
      out_hi_q    <= '0;
      out_flags_q <= '0;
      out_tag_q   <= '0;
      mul_tag_q   <= '0;
    end else begin
      st_q        <= st_d;
      out_valid_q <= out_valid_d;
      out_lo_q    <= out_lo_d;
      out_hi_q    <= out_hi_d;
      out_flags_q <= out_flags_d;
      out_tag_q   <= out_tag_d;
      mul_tag_q   <= mul_tag_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_lo    = out_lo_q;
  assign out_hi    = out_hi_q;
  assign out_flags = out_flags_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_alu_stream.sv
// Scoreboard bench for alu_stream: directed ops push expected results, a negedge monitor checks them.
module tb_alu_stream;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_lo;
  logic [WIDTH-1:0]  out_hi;
  logic [4:0]        out_flags;
  logic [TAG_W-1:0]  out_tag;

  alu_stream #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lo    (out_lo),
    .out_hi    (out_hi),
    .out_flags (out_flags),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
    int               acc_cyc;
    int               lat;
    bit               chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   head_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with out_valid compares against the scoreboard head; pops on transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got tag %0h lo %0h, expected no result", out_tag, out_lo);
      end else begin
        if (!head_seen && sb[0].chk_lat) check("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
        head_seen = 1'b1;
        check("out_lo", 32'(out_lo), 32'(sb[0].lo));
        check("out_hi", 32'(out_hi), 32'(sb[0].hi));
        check("out_flags", 32'(out_flags), 32'(sb[0].flags));
        check("out_tag", 32'(out_tag), 32'(sb[0].tag));
        if (out_ready) begin
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag, input logic [7:0] elo, input logic [7:0] ehi,
                      input logic [4:0] efl, input int lat, input bit chk);
    exp_t e;
    bit   done = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.lo      = elo;
        e.hi      = ehi;
        e.flags   = efl;
        e.tag     = tag;
        e.acc_cyc = cyc;
        e.lat     = lat;
        e.chk_lat = chk;
        sb.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected accept of op %0h", op);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_lo", 32'(out_lo), 0);
    check("rst_out_hi", 32'(out_hi), 0);
    check("rst_out_flags", 32'(out_flags), 0);
    check("rst_out_tag", 32'(out_tag), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD with carry out to zero
    send(4'h0, 8'hFF, 8'h01, 4'h3, 8'h00, 8'h00, 5'h05, 1, 1'b1);
    drain();

    // SUB overflow and SUB borrow
    send(4'h1, 8'h80, 8'h01, 4'h1, 8'h7F, 8'h00, 5'h02, 1, 1'b1);
    send(4'h1, 8'h00, 8'h01, 4'h2, 8'hFF, 8'h00, 5'h09, 1, 1'b1);
    drain();

    // MUL latency and in_ready low while multiplying
    send(4'hA, 8'hFF, 8'hFF, 4'h1, 8'h01, 8'hFE, 5'h08, 9, 1'b1);
    for (int i = 0; i < int'(WIDTH); i++) begin
      @(negedge clk);
      check("in_ready_mul", 32'(in_ready), 0);
    end
    drain();
    send(4'hA, 8'h0C, 8'h0B, 4'h2, 8'h84, 8'h00, 5'h00, 9, 1'b1);
    drain();
    send(4'hA, 8'h00, 8'h37, 4'h3, 8'h00, 8'h00, 5'h04, 9, 1'b1);
    drain();

    // Back-to-back ADDs with a 3-cycle consumer stall
    out_ready = 1'b1;
    fork
      begin
        send(4'h0, 8'h01, 8'h02, 4'h4, 8'h03, 8'h00, 5'h00, 1, 1'b0);
        send(4'h0, 8'h10, 8'h20, 4'h5, 8'h30, 8'h00, 5'h00, 1, 1'b0);
        send(4'h0, 8'h7F, 8'h01, 4'h6, 8'h80, 8'h00, 5'h0A, 1, 1'b0);
        send(4'h0, 8'h80, 8'h80, 4'h7, 8'h00, 8'h00, 5'h07, 1, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("in_ready_stall", 32'(in_ready), 0);
          check("out_valid_stall", 32'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Illegal opcode, shifts, logic ops and compares, streamed at full rate
    send(4'hF, 8'h12, 8'h34, 4'h8, 8'h00, 8'h00, 5'h14, 1, 1'b1);
    send(4'h7, 8'h90, 8'h02, 4'h9, 8'hE4, 8'h00, 5'h08, 1, 1'b1);
    send(4'h8, 8'hFF, 8'h01, 4'hA, 8'h01, 8'h00, 5'h00, 1, 1'b1);
    send(4'h9, 8'hFF, 8'h01, 4'hB, 8'h00, 8'h00, 5'h04, 1, 1'b1);
    send(4'h2, 8'hF0, 8'h3C, 4'hC, 8'h30, 8'h00, 5'h00, 1, 1'b1);
    send(4'h3, 8'hF0, 8'h0C, 4'hD, 8'hFC, 8'h00, 5'h08, 1, 1'b1);
    send(4'h4, 8'hAA, 8'hFF, 4'hE, 8'h55, 8'h00, 5'h00, 1, 1'b1);
    send(4'h5, 8'h81, 8'h09, 4'hF, 8'h02, 8'h00, 5'h00, 1, 1'b1);
    send(4'h6, 8'h81, 8'h09, 4'h0, 8'h40, 8'h00, 5'h00, 1, 1'b1);
    drain();

    // Reset three cycles into a MUL discards it
    send(4'hA, 8'h05, 8'h07, 4'h6, 8'h23, 8'h00, 5'h00, 9, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    head_seen = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_lo", 32'(out_lo), 0);
    check("midrst_out_hi", 32'(out_hi), 0);
    check("midrst_out_flags", 32'(out_flags), 0);
    check("midrst_out_tag", 32'(out_tag), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_no_result", 32'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(4'h0, 8'h05, 8'h06, 4'h9, 8'h0B, 8'h00, 5'h00, 1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
